// File: rtl/onehot_dec_pkg.sv
// Shared types for the registered one-hot decoder: FSM state encoding and command mode constants.
package onehot_dec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    SWEEP = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SWEEP  = 1'b1;

endpackage

// File: rtl/onehot_dec_core.sv
// Purely combinational index -> one-hot decode, 2**SEL_W outputs.
module onehot_dec_core #(
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0]      idx,
  output logic [(1<<SEL_W)-1:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered binary-to-one-hot decoder with valid/ready commands and a timed sweep mode.
// Build option: define DEC_ACTIVE_LOW_EN to drive the y port inverted (idle all-ones, selected bit 0).
module onehot_decoder_seq
  import onehot_dec_pkg::*;
#(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  mode,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [(1<<SEL_W)-1:0] y,
  output logic                  y_valid,
  output logic                  busy,
  output logic                  done,
  output state_e                state_dbg
);

  localparam int OUT_W = 1 << SEL_W;

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   y_q, y_d;
  logic               y_valid_q, y_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [SEL_W-1:0]   pos_q, pos_d;
  logic [DWELL_W-1:0] dcnt_q, dcnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;

  logic               accept;
  logic [SEL_W-1:0]   idx_step;
  logic [SEL_W-1:0]   dec_idx;
  logic [OUT_W-1:0]   dec_y;

  // Handshake: a command transfers on a rising clk edge where in_valid && in_ready;
  // in_ready never depends on in_valid, and is low while frozen, clearing or sweeping.
  assign in_ready = en && !clr && (state_q != SWEEP);
  assign accept   = in_valid && in_ready;

  // idx wraps OUT_W-1 -> 0 naturally because it is exactly SEL_W bits wide.
  assign idx_step = idx_q + 1'b1;
  assign dec_idx  = accept ? sel : idx_step;

  onehot_dec_core #(.SEL_W(SEL_W)) u_core (
    .idx    (dec_idx),
    .onehot (dec_y)
  );

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    busy_d    = busy_q;
    done_d    = done_q;
    idx_d     = idx_q;
    pos_d     = pos_q;
    dcnt_d    = dcnt_q;
    dwell_d   = dwell_q;
    if (en) begin
      done_d = 1'b0;
      if (clr) begin
        state_d   = IDLE;
        y_d       = '0;
        y_valid_d = 1'b0;
        busy_d    = 1'b0;
        idx_d     = '0;
        pos_d     = '0;
        dcnt_d    = '0;
      end else if (accept) begin
        y_d       = dec_y;
        y_valid_d = 1'b1;
        idx_d     = sel;
        pos_d     = '0;
        dcnt_d    = '0;
        if (mode == MODE_SWEEP) begin
          state_d = SWEEP;
          busy_d  = 1'b1;
          dwell_d = dwell;
        end else begin
          state_d = HOLD;
          busy_d  = 1'b0;
        end
      end else if (state_q == SWEEP) begin
        if (dcnt_q == dwell_q) begin
          dcnt_d = '0;
          // pos counts positions already completed; all-ones means the last one just ended.
          if (&pos_q) begin
            state_d   = IDLE;
            y_d       = '0;
            y_valid_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
          end else begin
            idx_d = idx_step;
            pos_d = pos_q + 1'b1;
            y_d   = dec_y;
          end
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      idx_q     <= '0;
      pos_q     <= '0;
      dcnt_q    <= '0;
      dwell_q   <= '0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      idx_q     <= idx_d;
      pos_q     <= pos_d;
      dcnt_q    <= dcnt_d;
      dwell_q   <= dwell_d;
    end
  end

`ifdef DEC_ACTIVE_LOW_EN
  assign y = ~y_q;
`else
  assign y = y_q;
`endif

  assign y_valid   = y_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Self-checking bench for onehot_decoder_seq: SEL_W=2 and SEL_W=3 instances, expected y via a queue.
module tb_onehot_decoder_seq;
  import onehot_dec_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       en        = 1'b1;
  logic       clr       = 1'b0;
  logic       in_valid  = 1'b0;
  logic       in_valid3 = 1'b0;
  logic       mode      = 1'b0;
  logic [1:0] sel       = '0;
  logic [2:0] sel3      = '0;
  logic [3:0] dwell     = '0;

  logic       in_ready, y_valid, busy, done;
  logic [3:0] y;
  state_e     state_dbg;
  logic       in_ready3, y_valid3, busy3, done3;
  logic [7:0] y3;
  state_e     state_dbg3;

  onehot_decoder_seq #(.SEL_W(2), .DWELL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .mode(mode), .dwell(dwell), .y(y), .y_valid(y_valid), .busy(busy),
    .done(done), .state_dbg(state_dbg)
  );

  onehot_decoder_seq #(.SEL_W(3), .DWELL_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .in_valid(in_valid3), .in_ready(in_ready3),
    .sel(sel3), .mode(mode), .dwell(dwell), .y(y3), .y_valid(y_valid3), .busy(busy3),
    .done(done3), .state_dbg(state_dbg3)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Active-high expected value mapped onto the y port polarity of this build.
  function automatic logic [7:0] port_y(input logic [7:0] v, input int w);
    logic [7:0] m;
    m = 8'((1 << w) - 1);
`ifdef DEC_ACTIVE_LOW_EN
    return ~v & m;
`else
    return v & m;
`endif
  endfunction

  task automatic pop_cmp(input string tag, input logic [7:0] got, input int w);
    logic [7:0] e;
    check({tag, "_queue"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(tag, 32'(got), 32'(port_y(e, w)));
    end
  endtask

  task automatic push_sweep(input int s, input int d, input int out_w);
    for (int p = 0; p < out_w; p++)
      for (int r = 0; r <= d; r++)
        exp_q.push_back(8'(1 << ((s + p) % out_w)));
    exp_q.push_back(8'h00);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic m, input logic [1:0] s, input logic [3:0] d);
    in_valid = 1'b1;
    mode     = m;
    sel      = s;
    dwell    = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int en_cycles;

    #1;
    check("rst_y", 32'(y), 32'(port_y(8'h00, 4)));
    check("rst_y_valid", 32'(y_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    tick;
    rst_n = 1'b1;
    tick;

    // Direct decode, hold, then back-to-back updates.
    exp_q.push_back(8'b0100);
    drive_cmd(MODE_DIRECT, 2'd2, 4'd0);
    tick;
    in_valid = 1'b0;
    pop_cmp("direct_sel2", 8'(y), 4);
    check("direct_y_valid", 32'(y_valid), 1);
    check("direct_state", 32'(state_dbg), 32'(HOLD));
    repeat (3) tick;
    check("direct_hold", 32'(y), 32'(port_y(8'b0100, 4)));
    foreach (sel[i]) begin end
    for (int i = 0; i < 4; i++) begin
      logic [1:0] s;
      s = (i == 0) ? 2'd3 : 2'($urandom_range(0, 3));
      exp_q.push_back(8'(1 << s));
      drive_cmd(MODE_DIRECT, s, 4'd0);
      tick;
      pop_cmp("direct_b2b", 8'(y), 4);
    end
    in_valid = 1'b0;
    tick;

    // Sweep from 2 with dwell 1: wraps 3 -> 0, ignores commands while sweeping.
    push_sweep(2, 1, 4);
    drive_cmd(MODE_SWEEP, 2'd2, 4'd1);
    for (int k = 0; k < 8; k++) begin
      tick;
      pop_cmp("sweep_y", 8'(y), 4);
      check("sweep_busy", 32'(busy), 1);
      check("sweep_done_low", 32'(done), 0);
      in_valid = (k != 7);
      sel      = 2'($urandom_range(0, 3));
      mode     = 1'($urandom_range(0, 1));
      dwell    = 4'($urandom_range(0, 15));
      #1;
      check("sweep_in_ready", 32'(in_ready), 0);
    end
    tick;
    pop_cmp("sweep_end_y", 8'(y), 4);
    check("sweep_done", 32'(done), 1);
    check("sweep_end_busy", 32'(busy), 0);
    check("sweep_end_y_valid", 32'(y_valid), 0);
    check("sweep_end_in_ready", 32'(in_ready), 1);
    tick;
    check("sweep_done_once", 32'(done), 0);

    // Abort on the third sweep cycle with a competing command.
    for (int k = 0; k < 3; k++) exp_q.push_back(8'b0001);
    drive_cmd(MODE_SWEEP, 2'd0, 4'd3);
    for (int k = 0; k < 3; k++) begin
      tick;
      in_valid = 1'b0;
      pop_cmp("abort_pre_y", 8'(y), 4);
    end
    clr = 1'b1;
    drive_cmd(MODE_DIRECT, 2'd1, 4'd0);
    #1;
    check("abort_in_ready", 32'(in_ready), 0);
    tick;
    clr      = 1'b0;
    in_valid = 1'b0;
    check("abort_y", 32'(y), 32'(port_y(8'h00, 4)));
    check("abort_busy", 32'(busy), 0);
    check("abort_y_valid", 32'(y_valid), 0);
    check("abort_no_done", 32'(done), 0);
    check("abort_state", 32'(state_dbg), 32'(IDLE));
    tick;
    check("abort_dropped", 32'(y), 32'(port_y(8'h00, 4)));
    check("abort_no_done2", 32'(done), 0);

    // Freeze mid-sweep (dwell 0), then stretch the done pulse.
    push_sweep(1, 0, 4);
    en_cycles = 0;
    drive_cmd(MODE_SWEEP, 2'd1, 4'd0);
    tick;
    in_valid = 1'b0;
    pop_cmp("freeze_y", 8'(y), 4);
    if (busy) en_cycles++;
    tick;
    pop_cmp("freeze_y", 8'(y), 4);
    if (busy) en_cycles++;
    en = 1'b0;
    repeat (5) begin
      tick;
      check("freeze_hold_y", 32'(y), 32'(port_y(8'b0100, 4)));
      check("freeze_in_ready", 32'(in_ready), 0);
    end
    en = 1'b1;
    repeat (2) begin
      tick;
      pop_cmp("freeze_y", 8'(y), 4);
      if (busy) en_cycles++;
    end
    check("freeze_en_cycles", 32'(en_cycles), 4);
    tick;
    pop_cmp("freeze_end_y", 8'(y), 4);
    check("freeze_done", 32'(done), 1);
    en = 1'b0;
    repeat (3) begin
      tick;
      check("done_stretch", 32'(done), 1);
    end
    en = 1'b1;
    tick;
    check("done_after_stretch", 32'(done), 0);

    // Asynchronous reset in the middle of a sweep.
    drive_cmd(MODE_SWEEP, 2'd3, 4'd2);
    tick;
    in_valid = 1'b0;
    check("pre_reset_y", 32'(y), 32'(port_y(8'b1000, 4)));
    tick;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_y", 32'(y), 32'(port_y(8'h00, 4)));
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_y_valid", 32'(y_valid), 0);
    check("async_rst_state", 32'(state_dbg), 32'(IDLE));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick;

    // SEL_W = 3 instance: sweep from 7, dwell 0.
    push_sweep(7, 0, 8);
    in_valid3 = 1'b1;
    sel3      = 3'd7;
    mode      = MODE_SWEEP;
    dwell     = 4'd0;
    for (int k = 0; k < 8; k++) begin
      tick;
      in_valid3 = 1'b0;
      pop_cmp("w3_y", y3, 8);
      check("w3_busy", 32'(busy3), 1);
    end
    tick;
    pop_cmp("w3_end_y", y3, 8);
    check("w3_done", 32'(done3), 1);
    tick;
    check("w3_done_once", 32'(done3), 0);

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
